uart_rx_word_packer: RTL and testbench

UART_RX_WORD_PACKER -- requirements
Module: uart_rx_word_packer

---
 rtl/uart_rx_word_packer_if.sv | 30 +++
 rtl/uart_rx_word_packer.sv | 132 +++++++++++++
 tb/tb_uart_rx_word_packer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_word_packer_if.sv
// Byte-in / word-out bundle for the UART word packer.
// The slave modport is the packer side; the master modport is the receiver/consumer side.
interface uart_rx_word_packer_if #(
  parameter int unsigned UART_DATA_WIDTH   = 8,
  parameter int unsigned CONFIG_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH        = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                         i_Rx_DV;
  logic [UART_DATA_WIDTH-1:0]   i_Rx_Byte;
  logic [CONFIG_DATA_WIDTH-1:0] i_Timeout;
  logic                         i_Word_Ready;
  logic                         i_Clear_Err;
  logic                         o_Word_Valid;
  logic [CONFIG_DATA_WIDTH-1:0] o_Word;
  logic [CNT_W-1:0]             o_Fifo_Count;
  logic                         o_Overflow;
  logic                         o_Timeout_Err;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Timeout, i_Word_Ready, i_Clear_Err,
    input  o_Word_Valid, o_Word, o_Fifo_Count, o_Overflow, o_Timeout_Err
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Timeout, i_Word_Ready, i_Clear_Err,
    output o_Word_Valid, o_Word, o_Fifo_Count, o_Overflow, o_Timeout_Err
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs four UART bytes little-endian into a word and queues words in a
// first-word-fall-through FIFO, with an inter-byte timeout and sticky overflow.
module uart_rx_word_packer #(
  parameter int unsigned UART_DATA_WIDTH   = 8,
  parameter int unsigned CONFIG_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input logic                  i_Clock,
  input logic                  i_Reset,
  uart_rx_word_packer_if.slave bus
);
  localparam int unsigned UW    = UART_DATA_WIDTH;
  localparam int unsigned CW    = CONFIG_DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [0:0] {S_IDLE, S_COLLECT} state_e;

  state_e           state_q;
  logic [1:0]       idx_q;
  logic [CW-1:0]    word_q;
  logic [CW-1:0]    timeout_q;
  logic [CW-1:0]    timer_q;
  logic             timeout_err_q;

  logic [CW-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic             timeout_hit;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;
  logic [CW-1:0]    push_word;

  // Completed word: held bytes 0..2 plus the byte arriving now as byte 3.
  always_comb begin
    push_word = word_q;
    push_word[3*UW +: UW] = bus.i_Rx_Byte;
  end

  assign timeout_hit = (state_q == S_COLLECT) && !bus.i_Rx_DV &&
                       (timeout_q != '0) && (timer_q >= timeout_q - CW'(1));
  assign push    = (state_q == S_COLLECT) && bus.i_Rx_DV && (idx_q == 2'd3);
  assign pop     = (count_q != '0) && bus.i_Word_Ready;
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Byte collection FSM; an arriving byte always beats a timeout.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q       <= S_IDLE;
      idx_q         <= 2'd0;
      word_q        <= '0;
      timeout_q     <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_Rx_DV) begin
            word_q    <= CW'(bus.i_Rx_Byte);
            idx_q     <= 2'd1;
            timeout_q <= bus.i_Timeout;
            timer_q   <= '0;
            state_q   <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (bus.i_Rx_DV) begin
            timer_q <= '0;
            if (idx_q == 2'd3) begin
              idx_q   <= 2'd0;
              state_q <= S_IDLE;
            end else begin
              word_q[32'(idx_q) * UW +: UW] <= bus.i_Rx_Byte;
              idx_q                         <= idx_q + 2'd1;
            end
          end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
            idx_q         <= 2'd0;
            timer_q       <= '0;
            state_q       <= S_IDLE;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset: the count gates everything visible.
  always_ff @(posedge i_Clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop)
        count_q <= count_q + CNT_W'(1);
      else if (pop && !push_ok)
        count_q <= count_q - CNT_W'(1);
      // A fresh drop outranks a clear in the same cycle.
      if (drop)
        overflow_q <= 1'b1;
      else if (bus.i_Clear_Err)
        overflow_q <= 1'b0;
    end
  end

  assign bus.o_Word_Valid  = (count_q != '0);
  assign bus.o_Word        = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.o_Fifo_Count  = count_q;
  assign bus.o_Overflow    = overflow_q;
  assign bus.o_Timeout_Err = timeout_err_q;
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer: word packing, timeout, FIFO full/overflow/wrap and reset.
module tb_uart_rx_word_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  uart_rx_word_packer_if #(.UART_DATA_WIDTH(8), .CONFIG_DATA_WIDTH(32), .FIFO_DEPTH(4)) bus ();

  uart_rx_word_packer #(.UART_DATA_WIDTH(8), .CONFIG_DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs and observations both live 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    tick();
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = w[8*k +: 8];
      send_byte(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Rx_DV = 1'b1;
    bus.i_Rx_Byte = 8'h5A;
    tick(); tick();
    bus.i_Rx_DV = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if (bus.o_Word_Valid !== 1'b0 || bus.o_Word !== 32'h0 || bus.o_Fifo_Count !== 3'd0)
      $display("FAIL reset_fifo: valid=%b word=%h count=%0d required 0/0/0",
               bus.o_Word_Valid, bus.o_Word, bus.o_Fifo_Count);
    else passed++;
    total++;
    if (bus.o_Overflow !== 1'b0 || bus.o_Timeout_Err !== 1'b0)
      $display("FAIL reset_flags: ovf=%b terr=%b required 0/0", bus.o_Overflow, bus.o_Timeout_Err);
    else passed++;
  endtask

  task automatic test_basic_word();
    bus.i_Timeout = 32'd0;
    bus.i_Word_Ready = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    total++;
    if (bus.o_Word_Valid !== 1'b0)
      $display("FAIL basic_partial_valid: got %b required 0", bus.o_Word_Valid);
    else passed++;
    send_byte(8'h44);
    total++;
    if (bus.o_Word_Valid !== 1'b1 || bus.o_Word !== 32'h44332211)
      $display("FAIL basic_word: valid=%b word=%h required 1/44332211", bus.o_Word_Valid, bus.o_Word);
    else passed++;
    tick();
    total++;
    if (bus.o_Word_Valid !== 1'b0 || bus.o_Word !== 32'h0)
      $display("FAIL basic_popped: valid=%b word=%h required 0/00000000", bus.o_Word_Valid, bus.o_Word);
    else passed++;
  endtask

  task automatic test_timeout();
    int n;
    bus.i_Word_Ready = 1'b1;
    bus.i_Timeout = 32'd100;
    send_byte(8'hAA); send_byte(8'hBB);
    n = 0;
    while (bus.o_Timeout_Err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n !== 100)
      $display("FAIL timeout_latency: pulse after %0d clocks required 100", n);
    else passed++;
    tick();
    total++;
    if (bus.o_Timeout_Err !== 1'b0 || bus.o_Word_Valid !== 1'b0)
      $display("FAIL timeout_pulse_width: terr=%b valid=%b required 0/0", bus.o_Timeout_Err, bus.o_Word_Valid);
    else passed++;
    send_word(32'h04030201);
    total++;
    if (bus.o_Word_Valid !== 1'b1 || bus.o_Word !== 32'h04030201)
      $display("FAIL timeout_clean_word: valid=%b word=%h required 1/04030201", bus.o_Word_Valid, bus.o_Word);
    else passed++;
    tick();
    // short timeout: err pulse appears exactly 5 clocks after the byte
    bus.i_Timeout = 32'd5;
    send_byte(8'hC1);
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (bus.o_Timeout_Err !== 1'b0)
      $display("FAIL timeout5_early: terr=%b after 4 clocks required 0", bus.o_Timeout_Err);
    else passed++;
    tick();
    total++;
    if (bus.o_Timeout_Err !== 1'b1)
      $display("FAIL timeout5_exact: terr=%b after 5 clocks required 1", bus.o_Timeout_Err);
    else passed++;
    tick();
  endtask

  task automatic test_timeout_disabled();
    logic seen;
    bus.i_Word_Ready = 1'b1;
    bus.i_Timeout = 32'd0;
    send_byte(8'hD0);
    bus.i_Timeout = 32'd3;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.o_Timeout_Err === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL timeout_disabled: terr seen=%b required 0", seen);
    else passed++;
    send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
    total++;
    if (bus.o_Word !== 32'hD3D2D1D0)
      $display("FAIL timeout_disabled_word: word=%h required D3D2D1D0", bus.o_Word);
    else passed++;
    tick();
  endtask

  task automatic test_dv_on_timeout();
    bus.i_Word_Ready = 1'b1;
    bus.i_Timeout = 32'd5;
    send_byte(8'h10);
    for (int i = 0; i < 4; i++) tick();
    send_byte(8'h20);
    total++;
    if (bus.o_Timeout_Err !== 1'b0)
      $display("FAIL dv_on_timeout_err: terr=%b required 0", bus.o_Timeout_Err);
    else passed++;
    send_byte(8'h30); send_byte(8'h40);
    total++;
    if (bus.o_Word_Valid !== 1'b1 || bus.o_Word !== 32'h40302010)
      $display("FAIL dv_on_timeout_word: valid=%b word=%h required 1/40302010", bus.o_Word_Valid, bus.o_Word);
    else passed++;
    tick();
  endtask

  task automatic test_overflow();
    logic [31:0] w [5];
    w[0] = 32'hA0A1A2A3; w[1] = 32'hB0B1B2B3; w[2] = 32'hC0C1C2C3;
    w[3] = 32'hD0D1D2D3; w[4] = 32'hE0E1E2E3;
    bus.i_Timeout = 32'd0;
    bus.i_Word_Ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(w[i]);
    total++;
    if (bus.o_Fifo_Count !== 3'd4 || bus.o_Overflow !== 1'b0)
      $display("FAIL ovf_full: count=%0d ovf=%b required 4/0", bus.o_Fifo_Count, bus.o_Overflow);
    else passed++;
    send_word(w[4]);
    total++;
    if (bus.o_Fifo_Count !== 3'd4 || bus.o_Overflow !== 1'b1)
      $display("FAIL ovf_drop: count=%0d ovf=%b required 4/1", bus.o_Fifo_Count, bus.o_Overflow);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.o_Word_Valid !== 1'b1 || bus.o_Word !== w[i])
        $display("FAIL ovf_readback%0d: valid=%b word=%h required 1/%h", i, bus.o_Word_Valid, bus.o_Word, w[i]);
      else passed++;
      bus.i_Word_Ready = 1'b1;
      tick();
      bus.i_Word_Ready = 1'b0;
    end
    total++;
    if (bus.o_Fifo_Count !== 3'd0 || bus.o_Overflow !== 1'b1)
      $display("FAIL ovf_drained: count=%0d ovf=%b required 0/1", bus.o_Fifo_Count, bus.o_Overflow);
    else passed++;
    bus.i_Word_Ready = 1'b1;
    tick();
    bus.i_Word_Ready = 1'b0;
    total++;
    if (bus.o_Fifo_Count !== 3'd0)
      $display("FAIL ready_when_empty: count=%0d required 0", bus.o_Fifo_Count);
    else passed++;
    bus.i_Clear_Err = 1'b1;
    tick();
    bus.i_Clear_Err = 1'b0;
    total++;
    if (bus.o_Overflow !== 1'b0)
      $display("FAIL clear_err: ovf=%b required 0", bus.o_Overflow);
    else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] w [5];
    w[0] = 32'h0000B00B; w[1] = 32'h0C0C0C0C; w[2] = 32'h0D0D0D0D;
    w[3] = 32'h0E0E0E0E; w[4] = 32'h0F0F0F0F;
    bus.i_Timeout = 32'd0;
    bus.i_Word_Ready = 1'b0;
    // shift pointers off zero so the fill wraps
    send_word(32'h12345678);
    bus.i_Word_Ready = 1'b1;
    tick();
    bus.i_Word_Ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(w[i]);
    total++;
    if (bus.o_Fifo_Count !== 3'd4 || bus.o_Word !== w[0])
      $display("FAIL wrap_full: count=%0d head=%h required 4/%h", bus.o_Fifo_Count, bus.o_Word, w[0]);
    else passed++;
    send_byte(8'h0F); send_byte(8'h0F); send_byte(8'h0F);
    bus.i_Word_Ready = 1'b1;
    send_byte(8'h0F);
    bus.i_Word_Ready = 1'b0;
    total++;
    if (bus.o_Fifo_Count !== 3'd4 || bus.o_Overflow !== 1'b0)
      $display("FAIL full_push_pop: count=%0d ovf=%b required 4/0", bus.o_Fifo_Count, bus.o_Overflow);
    else passed++;
    for (int i = 1; i < 5; i++) begin
      total++;
      if (bus.o_Word !== w[i])
        $display("FAIL wrap_order%0d: word=%h required %h", i, bus.o_Word, w[i]);
      else passed++;
      bus.i_Word_Ready = 1'b1;
      tick();
      bus.i_Word_Ready = 1'b0;
    end
    total++;
    if (bus.o_Word_Valid !== 1'b0)
      $display("FAIL wrap_drained: valid=%b required 0", bus.o_Word_Valid);
    else passed++;
  endtask

  task automatic test_push_pop_nonfull();
    bus.i_Timeout = 32'd0;
    bus.i_Word_Ready = 1'b0;
    send_word(32'h11111111);
    send_byte(8'h22); send_byte(8'h22); send_byte(8'h22);
    bus.i_Word_Ready = 1'b1;
    send_byte(8'h22);
    bus.i_Word_Ready = 1'b0;
    total++;
    if (bus.o_Fifo_Count !== 3'd1 || bus.o_Word !== 32'h22222222)
      $display("FAIL push_pop_nonfull: count=%0d word=%h required 1/22222222", bus.o_Fifo_Count, bus.o_Word);
    else passed++;
    bus.i_Word_Ready = 1'b1;
    tick();
    bus.i_Word_Ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.i_Timeout = 32'd0;
    bus.i_Word_Ready = 1'b0;
    send_word(32'h01010101);
    send_word(32'h02020202);
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    rst = 1'b1;
    bus.i_Rx_DV = 1'b1;
    bus.i_Rx_Byte = 8'h99;
    tick(); tick();
    bus.i_Rx_DV = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if (bus.o_Word_Valid !== 1'b0 || bus.o_Word !== 32'h0 || bus.o_Fifo_Count !== 3'd0 ||
        bus.o_Overflow !== 1'b0 || bus.o_Timeout_Err !== 1'b0)
      $display("FAIL reset_mid_outputs: valid=%b word=%h count=%0d ovf=%b terr=%b required all 0",
               bus.o_Word_Valid, bus.o_Word, bus.o_Fifo_Count, bus.o_Overflow, bus.o_Timeout_Err);
    else passed++;
    send_word(32'h88776655);
    total++;
    if (bus.o_Fifo_Count !== 3'd1 || bus.o_Word !== 32'h88776655)
      $display("FAIL reset_mid_word: count=%0d word=%h required 1/88776655", bus.o_Fifo_Count, bus.o_Word);
    else passed++;
  endtask

  initial begin
    bus.i_Rx_DV      = 1'b0;
    bus.i_Rx_Byte    = 8'h00;
    bus.i_Timeout    = 32'd0;
    bus.i_Word_Ready = 1'b0;
    bus.i_Clear_Err  = 1'b0;
    test_reset();
    test_basic_word();
    test_timeout();
    test_timeout_disabled();
    test_dv_on_timeout();
    test_overflow();
    test_full_push_pop();
    test_push_pop_nonfull();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
